// File: rtl/motion_update_bcast_ctrl.sv
// Motion-update pass sequencer: round-robin arbitration of particle records onto the cache broadcast bus.
// Optional destination range check is built when MU_BCAST_RANGE_CHECK_EN is defined (adds drop_count).
//
// state      | meaning
// S_IDLE     | waiting for start, outputs quiet
// S_BROADCAST| cache write window open, arbitrating requesters
// S_DRAIN    | one cycle for the last broadcast beat to land, enable still high
// S_SWAP     | enable low while caches write count and flip buffers
// S_DONE     | single-cycle pass-complete pulse
module motion_update_bcast_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int CELL_ID_WIDTH = 4,
   parameter int NUM_REQ       = 4,
   parameter int NUM_CELL_X    = 4,
   parameter int NUM_CELL_Y    = 4,
   parameter int NUM_CELL_Z    = 4,
   parameter int SWAP_WAIT     = 3,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data,
   input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell,
   input  logic [NUM_REQ-1:0]                   req_done,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic                                 motion_update_enable,
   output logic [3*DATA_WIDTH-1:0]              out_data,
   output logic [3*CELL_ID_WIDTH-1:0]           out_dst_cell,
   output logic                                 out_data_valid,
   output logic                                 busy,
   output logic                                 done,
`ifdef MU_BCAST_RANGE_CHECK_EN
   output logic [CNT_WIDTH-1:0]                 drop_count,
`endif
   output logic [CNT_WIDTH-1:0]                 beat_count
);

   localparam int REC_W = 3*DATA_WIDTH;
   localparam int DST_W = 3*CELL_ID_WIDTH;
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int SWC_W = $clog2(SWAP_WAIT);

   typedef enum logic [2:0] {
      S_IDLE, S_BROADCAST, S_DRAIN, S_SWAP, S_DONE
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [SWC_W-1:0]   swap_cnt;
   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   gnt_idx;
   logic [PTR_W-1:0]   cand;
   logic               gnt_any;
   logic [REC_W-1:0]   sel_rec;
   logic [DST_W-1:0]   sel_dst;
   logic               keep;
   logic               xfer;
   logic               exit_cond;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return PTR_W'(sum);
   endfunction

   // Scan from the farthest offset down so the nearest valid requester to rr_ptr wins.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int off = NUM_REQ-1; off >= 0; off--) begin
         cand = wrap_inc(rr_ptr, off);
         if (req_valid[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            gnt_idx     = cand;
            gnt_any     = 1'b1;
         end
      end
   end

   assign sel_rec   = req_data[gnt_idx*REC_W +: REC_W];
   assign sel_dst   = req_dst_cell[gnt_idx*DST_W +: DST_W];
   assign req_ready = (state == S_BROADCAST) ? grant : '0;
   assign xfer      = (state == S_BROADCAST) && gnt_any;
   assign exit_cond = (&req_done) && !(|req_valid);

`ifdef MU_BCAST_RANGE_CHECK_EN
   assign keep = (int'(sel_dst[DST_W-1 -: CELL_ID_WIDTH]) < NUM_CELL_X) &&
                 (int'(sel_dst[2*CELL_ID_WIDTH-1 -: CELL_ID_WIDTH]) < NUM_CELL_Y) &&
                 (int'(sel_dst[CELL_ID_WIDTH-1:0]) < NUM_CELL_Z);
`else
   assign keep = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= S_IDLE;
         rr_ptr               <= '0;
         swap_cnt             <= '0;
         motion_update_enable <= 1'b0;
         out_data             <= '0;
         out_dst_cell         <= '0;
         out_data_valid       <= 1'b0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         beat_count           <= '0;
`ifdef MU_BCAST_RANGE_CHECK_EN
         drop_count           <= '0;
`endif
      end else begin
         done           <= 1'b0;
         out_data_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               motion_update_enable <= 1'b0;
               busy                 <= 1'b0;
               out_data             <= '0;
               out_dst_cell         <= '0;
               if (start) begin
                  state                <= S_BROADCAST;
                  motion_update_enable <= 1'b1;
                  busy                 <= 1'b1;
                  beat_count           <= '0;
`ifdef MU_BCAST_RANGE_CHECK_EN
                  drop_count           <= '0;
`endif
               end
            end
            S_BROADCAST: begin
               if (xfer) begin
                  rr_ptr <= wrap_inc(gnt_idx, 1);
                  if (keep) begin
                     out_data       <= sel_rec;
                     out_dst_cell   <= sel_dst;
                     out_data_valid <= 1'b1;
                     if (beat_count != '1) beat_count <= beat_count + 1'b1;
                  end
`ifdef MU_BCAST_RANGE_CHECK_EN
                  else if (drop_count != '1) begin
                     drop_count <= drop_count + 1'b1;
                  end
`endif
               end
               if (exit_cond) state <= S_DRAIN;
            end
            S_DRAIN: begin
               state                <= S_SWAP;
               motion_update_enable <= 1'b0;
               swap_cnt             <= SWC_W'(SWAP_WAIT-1);
            end
            S_SWAP: begin
               if (swap_cnt == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  swap_cnt <= swap_cnt - 1'b1;
               end
            end
            S_DONE: begin
               state        <= S_IDLE;
               busy         <= 1'b0;
               out_data     <= '0;
               out_dst_cell <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_motion_update_bcast_ctrl.sv
// Scoreboard bench for motion_update_bcast_ctrl: requester model drives records, expected
// broadcasts are queued on grant and popped when out_data_valid appears.
module tb_motion_update_bcast_ctrl;

   localparam int DW    = 32;
   localparam int CW    = 4;
   localparam int NR    = 4;
   localparam int SW    = 3;
   localparam int CNTW  = 16;
   localparam int REC_W = 3*DW;
   localparam int DST_W = 3*CW;

   logic                  clk = 1'b0;
   logic                  rst, start;
   logic [NR-1:0]         req_valid, req_done, req_ready;
   logic [NR*REC_W-1:0]   req_data;
   logic [NR*DST_W-1:0]   req_dst_cell;
   logic                  motion_update_enable, out_data_valid, busy, done;
   logic [REC_W-1:0]      out_data;
   logic [DST_W-1:0]      out_dst_cell;
   logic [CNTW-1:0]       beat_count, drop_count;

   motion_update_bcast_ctrl #(
      .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .NUM_REQ(NR),
      .NUM_CELL_X(4), .NUM_CELL_Y(4), .NUM_CELL_Z(4),
      .SWAP_WAIT(SW), .CNT_WIDTH(CNTW)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .req_valid(req_valid), .req_data(req_data), .req_dst_cell(req_dst_cell),
      .req_done(req_done), .req_ready(req_ready),
      .motion_update_enable(motion_update_enable),
      .out_data(out_data), .out_dst_cell(out_dst_cell), .out_data_valid(out_data_valid),
      .busy(busy), .done(done),
`ifdef MU_BCAST_RANGE_CHECK_EN
      .drop_count(drop_count),
`endif
      .beat_count(beat_count)
   );

`ifndef MU_BCAST_RANGE_CHECK_EN
   assign drop_count = '0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [REC_W-1:0] d;
      logic [DST_W-1:0] c;
   } rec_t;

   rec_t sb[$];
   int   gq[$];
   int   rem[NR];
   int   seq[NR];
   int   bad_seq;
   int   rr_m;
   int   last_d, last_beats, last_drops;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [REC_W-1:0] rec_data(int i, int s);
      logic [31:0] p;
      p = 32'(i*256 + s);
      return {p ^ 32'hA5A5_A5A5, ~p, p};
   endfunction

   function automatic logic [DST_W-1:0] rec_dst(int i, int s);
      logic [CW-1:0] x;
      x = (i == 0 && s == bad_seq) ? 4'd4 : CW'(s % 4);
      return {x, CW'(i), CW'((s + i) % 4)};
   endfunction

   function automatic bit is_drop(int i, int s);
`ifdef MU_BCAST_RANGE_CHECK_EN
      logic [DST_W-1:0] t;
      t = rec_dst(i, s);
      return (t[11:8] >= 4) || (t[7:4] >= 4) || (t[3:0] >= 4);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk_quiet(input string tag);
      chk_val({tag, "_ready"}, req_ready, '0);
      chk_val({tag, "_enable"}, motion_update_enable, 1'b0);
      chk_val({tag, "_out_data"}, out_data, '0);
      chk_val({tag, "_out_dst"}, out_dst_cell, '0);
      chk_val({tag, "_valid"}, out_data_valid, 1'b0);
      chk_val({tag, "_busy"}, busy, 1'b0);
      chk_val({tag, "_done"}, done, 1'b0);
      chk_val({tag, "_beat_count"}, beat_count, '0);
      chk_val({tag, "_drop_count"}, drop_count, '0);
   endtask

   task automatic run_pass(input bit gap_en, input bit early_done, input bit mid_start, input bit rst_mid);
      int c, d, beats, drops, acc, gi, j;
      bit xfer_prev, in_post, dr;
      logic [NR-1:0] v, dn, eg;
      rec_t e;
      beats = 0; drops = 0; acc = 0; d = -1;
      xfer_prev = 1'b0; in_post = 1'b0;
      for (int i = 0; i < NR; i++) seq[i] = 0;
      sb.delete();
      gq.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 1;
      while (1) begin
         if (c > 3000) begin
            chk_val("cycle_budget", c, 0);
            break;
         end
         chk_val("data_valid", out_data_valid, xfer_prev);
         if (out_data_valid) begin
            if (sb.size() == 0) chk_val("sb_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               chk_val("out_data", out_data, e.d);
               chk_val("out_dst", out_dst_cell, e.c);
            end
         end
         if (!in_post) begin
            chk_val("bcast_busy", busy, 1'b1);
            chk_val("bcast_enable", motion_update_enable, 1'b1);
            if (rst_mid && acc == 2) begin
               rst = 1'b1;
               tick();
               rst = 1'b0;
               chk_quiet("mid_rst");
               rr_m = 0;
               last_d = -1;
               for (int k = 0; k < 8; k++) begin
                  tick();
                  chk_val("no_done_after_rst", done, 1'b0);
                  chk_val("idle_after_rst", busy, 1'b0);
               end
               req_valid = '0;
               req_done  = '0;
               return;
            end
            for (int i = 0; i < NR; i++) begin
               v[i]  = (rem[i] > 0) && (!gap_en || $urandom_range(0, 3) != 0);
               dn[i] = (rem[i] == 0) || (early_done && rem[i] == 1);
               req_data[i*REC_W +: REC_W]     = rec_data(i, seq[i]);
               req_dst_cell[i*DST_W +: DST_W] = rec_dst(i, seq[i]);
            end
            req_valid = v;
            req_done  = dn;
            #1;
            eg = '0;
            gi = -1;
            for (int off = 0; off < NR; off++) begin
               j = (rr_m + off) % NR;
               if (v[j] && gi < 0) gi = j;
            end
            if (gi >= 0) eg[gi] = 1'b1;
            chk_val("req_ready", req_ready, eg);
            xfer_prev = 1'b0;
            if (gi >= 0) begin
               acc++;
               gq.push_back(gi);
               rr_m = (gi + 1) % NR;
               dr = is_drop(gi, seq[gi]);
               if (dr) drops++;
               else begin
                  beats++;
                  e.d = rec_data(gi, seq[gi]);
                  e.c = rec_dst(gi, seq[gi]);
                  sb.push_back(e);
                  xfer_prev = 1'b1;
               end
               rem[gi]--;
               seq[gi]++;
            end
            if ((&dn) && !(|v)) begin
               in_post = 1'b1;
               d = c;
            end
            if (mid_start && c == 2) start = 1'b1;
         end else begin
            req_valid = '0;
            req_done  = '1;
            #1;
            chk_val("post_ready", req_ready, '0);
            chk_val("post_enable", motion_update_enable, c <= d + 1);
            chk_val("post_done", done, c == d + 2 + SW);
            chk_val("post_busy", busy, c <= d + 2 + SW);
            if (c == d + 2 + SW) begin
               chk_val("beat_count", beat_count, CNTW'(beats));
               chk_val("drop_count", drop_count, CNTW'(drops));
            end
            if (mid_start && c == d + 3) start = 1'b1;
            xfer_prev = 1'b0;
            if (c == d + 3 + SW) break;
         end
         tick();
         start = 1'b0;
         c++;
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         chk_val("single_done", done, 1'b0);
      end
      chk_val("sb_empty", sb.size(), 0);
      last_d = d;
      last_beats = beats;
      last_drops = drops;
      req_valid = '0;
      req_done  = '0;
   endtask

   initial begin
      int rs;
      rst = 1'b1; start = 1'b0;
      req_valid = '0; req_done = '0; req_data = '0; req_dst_cell = '0;
      bad_seq = -1; rr_m = 0; last_d = -1;
      repeat (3) tick();
      chk_quiet("reset");
      rst = 1'b0;
      tick();

      // Round-robin fairness with everyone continuously valid
      rem = '{4, 4, 4, 4};
      rs = rr_m;
      run_pass(1'b0, 1'b0, 1'b0, 1'b0);
      chk_val("rr_grants", gq.size(), 16);
      if (gq.size() >= 8)
         for (int k = 0; k < 8; k++) chk_val("rr_order", gq[k], (rs + k) % NR);
      chk_val("rr_beats", last_beats, 16);

      // Single requester, three back-to-back beats
      rem = '{3, 0, 0, 0};
      run_pass(1'b0, 1'b0, 1'b0, 1'b0);
      chk_val("single_exit_cycle", last_d, 4);
      chk_val("single_beats", last_beats, 3);

      // Empty pass
      rem = '{0, 0, 0, 0};
      run_pass(1'b0, 1'b0, 1'b0, 1'b0);
      chk_val("empty_exit_cycle", last_d, 1);
      chk_val("empty_beats", last_beats, 0);

      // Gapped valids plus stray start pulses during the pass
      rem = '{5, 2, 0, 6};
      run_pass(1'b1, 1'b0, 1'b1, 1'b0);
      chk_val("gap_beats", last_beats, 13);

      // req_done raised together with the final valid record
      rem = '{2, 3, 1, 2};
      run_pass(1'b0, 1'b1, 1'b0, 1'b0);
      chk_val("early_done_beats", last_beats, 8);

      // Reset after two beats, then a clean pass
      rem = '{3, 3, 3, 3};
      run_pass(1'b0, 1'b0, 1'b0, 1'b1);
      rem = '{2, 2, 0, 1};
      run_pass(1'b0, 1'b0, 1'b0, 1'b0);
      chk_val("post_rst_beats", last_beats, 5);

      // Out-of-grid destination on requester 0, second beat
      bad_seq = 1;
      rem = '{3, 0, 0, 0};
      run_pass(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MU_BCAST_RANGE_CHECK_EN
      chk_val("range_beats", last_beats, 2);
      chk_val("range_drops", last_drops, 1);
`else
      chk_val("range_beats", last_beats, 3);
      chk_val("range_drops", last_drops, 0);
`endif
      bad_seq = -1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
